// File: rtl/raw_bayer_demosaic.sv
// Bayer raw-to-RGB demosaic using a 2x2 window built from one line buffer.
// Two-stage pipeline: window capture, then colour select/average and output register.
module raw_bayer_demosaic #(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned LINE_W  = 640,
    parameter int unsigned VAL_MIN = 3,
    parameter int unsigned VAL_MAX = 637,
    parameter int unsigned BAYER   = 0
) (
    input  logic              VGA_CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iVALID,
    input  logic              iVS,
    input  logic              iMODE,
    output logic              oVALID,
    output logic [OUT_W-1:0]  oRed,
    output logic [OUT_W-1:0]  oGreen,
    output logic [OUT_W-1:0]  oBlue,
    output logic [10:0]       oX,
    output logic [10:0]       oY
);

    localparam int unsigned CW = 11;
    localparam int unsigned AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int unsigned SW = DATA_W + 1;
    localparam logic [1:0]    PAT    = 2'(BAYER);
    localparam logic [CW-1:0] X_LAST = CW'(LINE_W - 1);
    localparam logic [CW-1:0] X_MIN  = CW'(VAL_MIN);
    localparam logic [CW-1:0] X_MAX  = CW'(VAL_MAX);

    logic              accept;
    logic [CW-1:0]     xPos, yPos;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] lineBuf [LINE_W];

    logic              valid1;
    logic [CW-1:0]     x1, y1;
    logic [DATA_W-1:0] winCur, winPrev, winAbove, winAboveLeft;
    logic              modeLat;

    logic [1:0]        phase;
    logic [DATA_W-1:0] selRed, selBlue, selG1, selG2, gAvg;
    logic [SW-1:0]     gSum;
    logic              blank;
    logic [OUT_W-1:0]  pixRed, pixGreen, pixBlue;

    // Left-justify into OUT_W: keeps the MSBs when narrowing, zero-fills when widening.
    function automatic logic [OUT_W-1:0] toOut(input logic [DATA_W-1:0] v);
        return OUT_W'({v, {OUT_W{1'b0}}} >> DATA_W);
    endfunction

    assign accept = iVALID & iVS;
    assign addr   = xPos[AW-1:0];

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            xPos <= '0;
            yPos <= '0;
        end else if (!iVS) begin
            xPos <= '0;
            yPos <= '0;
        end else if (iVALID) begin
            if (xPos == X_LAST) begin
                xPos <= '0;
                yPos <= yPos + CW'(1);
            end else begin
                xPos <= xPos + CW'(1);
            end
        end
    end

    // Line buffer holds the previous row; contents are don't-care after reset.
    always_ff @(posedge VGA_CLK) begin
        if (accept) begin
            lineBuf[addr] <= iDATA;
        end
    end

    // Stage 1: shift the 2x2 window and capture the sample coordinate.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            valid1       <= 1'b0;
            x1           <= '0;
            y1           <= '0;
            winCur       <= '0;
            winPrev      <= '0;
            winAbove     <= '0;
            winAboveLeft <= '0;
            modeLat      <= 1'b0;
        end else begin
            valid1 <= accept;
            if (accept) begin
                x1           <= xPos;
                y1           <= yPos;
                winCur       <= iDATA;
                winPrev      <= winCur;
                winAbove     <= lineBuf[addr];
                winAboveLeft <= winAbove;
                if (xPos == '0) begin
                    modeLat <= iMODE;
                end
            end
        end
    end

    assign phase = {y1[0], x1[0]} ^ PAT;

    // Diagonal neighbours share a colour class; row/column neighbours swap R/B or G.
    always_comb begin
        selRed  = winCur;
        selBlue = winAboveLeft;
        selG1   = winPrev;
        selG2   = winAbove;
        case (phase)
            2'd0: begin
                selRed  = winCur;
                selBlue = winAboveLeft;
                selG1   = winPrev;
                selG2   = winAbove;
            end
            2'd1: begin
                selRed  = winPrev;
                selBlue = winAbove;
                selG1   = winCur;
                selG2   = winAboveLeft;
            end
            2'd2: begin
                selRed  = winAbove;
                selBlue = winPrev;
                selG1   = winCur;
                selG2   = winAboveLeft;
            end
            default: begin
                selRed  = winAboveLeft;
                selBlue = winCur;
                selG1   = winPrev;
                selG2   = winAbove;
            end
        endcase
    end

    assign gSum  = SW'(selG1) + SW'(selG2);
    assign gAvg  = DATA_W'(gSum >> 1);
    assign blank = (x1 <= X_MIN) | (x1 >= X_MAX) | ((y1 == '0) & ~modeLat);

    always_comb begin
        pixRed   = '0;
        pixGreen = '0;
        pixBlue  = '0;
        if (!blank) begin
            if (modeLat) begin
                pixRed   = toOut(winCur);
                pixGreen = toOut(winCur);
                pixBlue  = toOut(winCur);
            end else begin
                pixRed   = toOut(selRed);
                pixGreen = toOut(gAvg);
                pixBlue  = toOut(selBlue);
            end
        end
    end

    // Stage 2: outputs only move on a valid pixel and otherwise hold.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            oVALID <= 1'b0;
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
            oX     <= '0;
            oY     <= '0;
        end else begin
            oVALID <= valid1;
            if (valid1) begin
                oRed   <= pixRed;
                oGreen <= pixGreen;
                oBlue  <= pixBlue;
                oX     <= x1;
                oY     <= y1;
            end
        end
    end

endmodule

// File: doc/raw_bayer_demosaic.md
RAW_BAYER_DEMOSAIC -- requirements
Module: raw_bayer_demosaic

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, default 10, raw sample width.
- OUT_W, default 8, colour channel width.
- LINE_W, default 640, pixels per line.
- VAL_MIN, default 3, last blanked column at the left edge.
- VAL_MAX, default 637, first blanked column at the right edge.
- BAYER, default 0, pattern: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.

REQ-002 The block SHALL have these ports, clock and reset first:
- VGA_CLK  in  1  sole clock, all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- iDATA  in  DATA_W  raw Bayer sample.
- iVALID  in  1  sample strobe; iDATA is consumed only in a cycle where it is 1.
- iVS  in  1  active-low frame sync.
- iMODE  in  1  0 = demosaic, 1 = grey passthrough.
- oVALID  out  1  output strobe.
- oRed, oGreen, oBlue  out  OUT_W each  colour outputs.
- oX, oY  out  11 each  coordinate of the output pixel.

Function
REQ-003 X counter: +1 per accepted sample; at LINE_W-1 SHALL wrap to 0 and increment Y; Y SHALL wrap at 2047.
REQ-004 While iVS=0, X and Y SHALL be held at 0 and iVALID ignored (sample dropped, no oVALID); iVS=0 wins over a simultaneous iVALID.
REQ-005 Storage SHALL be one line buffer of LINE_W x DATA_W, read and written at address X in the same accepted cycle (read-before-write), giving the sample directly above.
REQ-006 A 2x2 window SHALL be formed from: current sample, previous sample in the line, above, above-left (delay registers updated only on accepted samples).
REQ-007 Phase SHALL be P = {Y[0],X[0]} XOR BAYER[1:0]:
- P=0: window sample at the current position is R.
- P=3: it is B.
- P=1 or 2: it is G.
- R, B and the two G positions SHALL be selected from the window accordingly.
REQ-008 Green SHALL be (G1+G2)>>1, computed at DATA_W+1 bits, no overflow.
REQ-009 Width conversion from DATA_W to OUT_W:
- OUT_W<=DATA_W: take the top OUT_W bits.
- OUT_W>DATA_W: left-justify, zero-fill the LSBs.
REQ-010 iMODE=1: R=G=B=current sample, width-converted per REQ-009.
REQ-011 iMODE SHALL be sampled only when X=0 at an accepted sample (line-granular); a mid-line change SHALL take effect on the next line.
REQ-012 Colour outputs SHALL be forced to 0 when any of these holds:
- X<=VAL_MIN
- X>=VAL_MAX
- Y=0 in demosaic mode
REQ-013 Pipeline timing:
- Latency from an accepted iVALID to its oVALID SHALL be exactly 2 cycles.
- oVALID SHALL pulse once per accepted sample.
- Gaps in iVALID SHALL propagate as gaps, with no reordering.
REQ-014 oX/oY SHALL equal the X/Y of the sample producing that output, pipelined alongside the data.
REQ-015 Outputs SHALL hold their values between oVALID pulses.
REQ-016 iVS falling mid-line SHALL NOT flush the pipeline: samples already accepted still emerge, and the next frame restarts at X=0, Y=0.

Reset
REQ-017 RST=1 SHALL asynchronously clear the following to 0:
- oVALID, oRed, oGreen, oBlue, oX, oY
- X, Y
- window registers
- latched mode
REQ-018 Line buffer contents SHALL be don't-care after reset; REQ-012 masks row 0.
REQ-019 Reset asserted mid-frame SHALL discard in-flight samples, with no oVALID until 2 cycles after the first accepted sample following RST release.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Defaults, RGGB frame of constant R=1020, G=512, B=4, iMODE=0 -> rows>=1, X in 4..636: oRed=255, oGreen=128, oBlue=1.
- Same frame with BAYER=3 -> oRed=1, oBlue=255.
- G1=1023, G2=1021 -> G sum 2044 kept at 11 bits, oGreen=255 (no wrap).
- iMODE=1, iDATA=0x2A8 -> oRed=oGreen=oBlue=0xAA; X=2 or X=640-3 -> all 0.
- iVALID pattern 1,0,1 -> oVALID pattern 1,0,1 exactly 2 cycles later.
- X=639 wrap -> next oY=Y+1, oX=0.
- iVS low while iVALID=1 -> no oVALID.
- RST pulse mid-line -> outputs 0 immediately, X=Y=0.
- OUT_W=12, DATA_W=10, iMODE=1, iDATA=0x3FF -> 0xFFC.
